eq_serial_ctrl: RTL and testbench

//  Sequencer that runs a wide W-bit equality test through one shared 2-bit equality slice.
//  It processes 2 bits per cycle, LSB slice first.
//  It accepts a start request when ready, then returns a registered result with a 1-cycle done pulse.
//  It also reports the index of the lowest mismatching slice.

---
 rtl/eq_serial_ctrl.sv | 120 ++++++++++++
 tb/tb_eq_serial_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/eq_serial_ctrl.sv
// Serial W-bit equality sequencer: compares 2 bits per cycle, LSB slice first,
// and reports the lowest mismatching slice. Optional macro: EARLY_EXIT_EN.
module eq_serial_ctrl #(
  parameter  int W  = 16,
  localparam int IW = $clog2(W / 2)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic          ready,
  output logic          done,
  output logic          aeqb,
  output logic [IW-1:0] mm_idx
);

  localparam int N = W / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMP,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          mis_q, mis_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          aeqb_q, aeqb_d;
  logic [IW-1:0] mm_q, mm_d;

  logic slice_eq;
  logic last_slice;
  logic comp_exit;

  assign slice_eq   = (sa_q[1:0] == sb_q[1:0]);
  assign last_slice = (cnt_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    idx_d   = idx_q;
    aeqb_d  = aeqb_q;
    mm_d    = mm_q;
`ifdef EARLY_EXIT_EN
    comp_exit = last_slice || !slice_eq;
`else
    comp_exit = last_slice;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = '0;
          mis_d   = 1'b0;
          idx_d   = '0;
          state_d = S_COMP;
        end
      end
      S_COMP: begin
        sa_d = sa_q >> 2;
        sb_d = sb_q >> 2;
        if (!last_slice) cnt_d = cnt_q + 1'b1;
        if (!slice_eq && !mis_q) begin
          mis_d = 1'b1;
          idx_d = cnt_q;
        end
        // Results latch from the _d values so the slice compared on the
        // exit cycle is included.
        if (comp_exit) begin
          aeqb_d  = ~mis_d;
          mm_d    = mis_d ? idx_d : '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      aeqb_q  <= 1'b0;
      mm_q    <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      idx_q   <= idx_d;
      aeqb_q  <= aeqb_d;
      mm_q    <= mm_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign done   = (state_q == S_DONE);
  assign aeqb   = aeqb_q;
  assign mm_idx = mm_q;

endmodule

// File: tb/tb_eq_serial_ctrl.sv
// Directed bench for eq_serial_ctrl at W=16; expected latencies follow EARLY_EXIT_EN.
module tb_eq_serial_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        done;
  logic        aeqb;
  logic [2:0]  mm_idx;

  int checks = 0;
  int errors = 0;

  eq_serial_ctrl #(.W(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .done   (done),
    .aeqb   (aeqb),
    .mm_idx (mm_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one op in the current cycle (cycle 0) and watches cycles 1..14.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input int exp_cyc, input logic exp_eq, input logic [2:0] exp_idx);
    int cyc;
    int ndone;
    cyc   = -1;
    ndone = 0;
    a     = ta;
    b     = tb_v;
    start = 1'b1;
    chk({tag, "_ready0"}, 32'(ready), 32'd1);
    tick();
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    for (int c = 1; c <= 14; c++) begin
      if (done) begin
        ndone++;
        if (cyc < 0) begin
          cyc = c;
          chk({tag, "_aeqb"}, 32'(aeqb), 32'(exp_eq));
          chk({tag, "_idx"}, 32'(mm_idx), 32'(exp_idx));
        end
      end
      tick();
    end
    chk({tag, "_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_ndone"}, 32'(ndone), 32'd1);
  endtask

  initial begin
    int ndone;
    int cyc;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aeqb", 32'(aeqb), 32'd0);
    chk("rst_idx", 32'(mm_idx), 32'd0);

    run_op("t1_equal", 16'hA5A5, 16'hA5A5, 9, 1'b1, 3'd0);

    // Abort an op with reset in cycle 4; aeqb was 1 from t1.
    a     = 16'h8000;
    b     = 16'h0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_ready", 32'(ready), 32'd1);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_aeqb", 32'(aeqb), 32'd0);
    chk("t6_idx", 32'(mm_idx), 32'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) ndone++;
      tick();
    end
    chk("t6_nodone", 32'(ndone), 32'd0);

`ifdef EARLY_EXIT_EN
    run_op("t2_lsb", 16'h0001, 16'h0000, 2, 1'b0, 3'd0);
    run_op("t4_two", 16'h0C30, 16'h0000, 4, 1'b0, 3'd2);
`else
    run_op("t2_lsb", 16'h0001, 16'h0000, 9, 1'b0, 3'd0);
    run_op("t4_two", 16'h0C30, 16'h0000, 9, 1'b0, 3'd2);
`endif

    for (int c = 0; c < 5; c++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
    end
    chk("hold_aeqb", 32'(aeqb), 32'd0);
    chk("hold_idx", 32'(mm_idx), 32'd2);

    run_op("t3_msb", 16'h8000, 16'h0000, 9, 1'b0, 3'd7);

    // Busy-time start pulses are dropped; a new start is taken in cycle 10.
    a     = 16'h1234;
    b     = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    cyc   = -1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 3 || c == 5) begin
        start = 1'b1;
        a     = 16'h0001;
        b     = 16'h0000;
        chk("t5_busy_ready", 32'(ready), 32'd0);
      end else begin
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (cyc < 0) cyc = c;
        chk("t5_aeqb", 32'(aeqb), 32'd1);
      end
      if (c == 10) begin
        chk("t5_ready10", 32'(ready), 32'd1);
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'hFFFF;
      end else begin
        tick();
      end
    end
    chk("t5_cycle", 32'(cyc), 32'd9);
    chk("t5_ndone", 32'(ndone), 32'd1);
    tick();
    start = 1'b0;
    chk("t5_ready11", 32'(ready), 32'd0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) begin
        ndone++;
        chk("t5b_aeqb", 32'(aeqb), 32'd1);
        chk("t5b_idx", 32'(mm_idx), 32'd0);
      end
      tick();
    end
    chk("t5b_ndone", 32'(ndone), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
